// File: rtl/mult_div_unit_if.sv
// Bundles the E-stage multiply/divide request and its results.
// The pipeline drives the master side; mult_div_unit is the slave.
interface mult_div_unit_if;
   logic [3:0]  mdOP;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDout;

   modport slave  (input mdOP, A, B, output start, busy, HI, LO, MDout);
   modport master (output mdOP, A, B, input start, busy, HI, LO, MDout);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style HI/LO unit. The result is computed on the start edge
// and held internally, then committed to HI/LO once the busy period has elapsed.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic             clk,
   input logic             reset,
   mult_div_unit_if.slave  bus
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_tempHi;
   logic [31:0]      r_tempLo;
   logic             r_commit;

   logic               w_isMult;
   logic               w_isDiv;
   logic               w_start;
   logic               w_signedDiv;
   logic signed [63:0] w_prodS;
   logic [63:0]        w_prodU;
   logic [31:0]        w_absA;
   logic [31:0]        w_absB;
   logic [31:0]        w_safeB;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;
   logic [31:0]        w_sq;
   logic [31:0]        w_sr;
   logic [63:0]        w_result;

   assign w_isMult = (bus.mdOP == OP_MULT) || (bus.mdOP == OP_MULTU);
   assign w_isDiv  = (bus.mdOP == OP_DIV)  || (bus.mdOP == OP_DIVU);
   assign w_start  = (w_isMult || w_isDiv) && (r_state == S_IDLE);

   assign w_prodS = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
   assign w_prodU = {32'd0, bus.A} * {32'd0, bus.B};

   // Signed division works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign w_signedDiv = (bus.mdOP == OP_DIV);
   assign w_absA  = (w_signedDiv && bus.A[31]) ? -bus.A : bus.A;
   assign w_absB  = (w_signedDiv && bus.B[31]) ? -bus.B : bus.B;
   assign w_safeB = (w_absB == 32'd0) ? 32'd1 : w_absB;
   assign w_uq    = w_absA / w_safeB;
   assign w_ur    = w_absA % w_safeB;
   assign w_sq    = (w_signedDiv && (bus.A[31] ^ bus.B[31])) ? -w_uq : w_uq;
   assign w_sr    = (w_signedDiv && bus.A[31]) ? -w_ur : w_ur;

   always_comb begin
      w_result = 64'd0;
      case (bus.mdOP)
         OP_MULT:         w_result = w_prodS;
         OP_MULTU:        w_result = w_prodU;
         OP_DIV, OP_DIVU: w_result = {w_sr, w_sq};
         default:         w_result = 64'd0;
      endcase
   end

   // A divide by zero still occupies the full busy period but never commits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_tempHi <= 32'd0;
         r_tempLo <= 32'd0;
         r_commit <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_tempHi <= w_result[63:32];
                  r_tempLo <= w_result[31:0];
                  r_cnt    <= w_isMult ? MULT_LOAD : DIV_LOAD;
                  r_commit <= !(w_isDiv && (bus.B == 32'd0));
                  r_state  <= S_RUN;
               end else if (bus.mdOP == OP_MTHI) begin
                  r_hi <= bus.A;
               end else if (bus.mdOP == OP_MTLO) begin
                  r_lo <= bus.A;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt <= CNT_ONE) begin
                  if (r_commit) begin
                     r_hi <= r_tempHi;
                     r_lo <= r_tempLo;
                  end
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.start = w_start;
   assign bus.busy  = (r_state == S_RUN);
   assign bus.HI    = r_hi;
   assign bus.LO    = r_lo;
   assign bus.MDout = (bus.mdOP == OP_MFHI) ? r_hi :
                      (bus.mdOP == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL expose parameter MULT_CYCLES, default 5, busy length of mult/multu.
REQ-002 SHALL expose parameter DIV_CYCLES, default 10, busy length of div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mdOP  input  4  E-stage op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none.
REQ-006 SHALL have port A  input  32  forwarded rs value.
REQ-007 SHALL have port B  input  32  forwarded rt value.
REQ-008 SHALL have port start  output  1  combinational: high when mdOP is 1-4 and busy is low.
REQ-009 SHALL have port busy  output  1  registered: operation in progress.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.
REQ-012 SHALL have port MDout  output  32  combinational: HI when mdOP=7, LO when mdOP=8, else 0.

Function
REQ-013 SHALL use a two-state FSM, IDLE (busy=0) and RUN (busy=1), with a down-counter cnt wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-014 In IDLE with start=1, SHALL on the clock edge latch the full 64-bit result into internal temp_hi/temp_lo, load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), and enter RUN.
REQ-015 In RUN, SHALL decrement cnt once per edge.
REQ-016 When cnt reaches 1, SHALL on that edge copy temp_hi/temp_lo into HI/LO and return to IDLE.
REQ-017 busy SHALL be high for exactly N cycles after the start edge, where N is the relevant CYCLES parameter.
REQ-018 HI/LO SHALL not change during RUN until the final edge.
REQ-019 mult SHALL compute the signed 32x32 to 64 product: HI = upper 32 bits, LO = lower 32 bits.
REQ-020 multu SHALL compute the unsigned 32x32 to 64 product, same HI/LO split.
REQ-021 div SHALL compute the signed quotient into LO, truncated toward zero, and the remainder into HI, with the remainder taking the sign of the dividend.
REQ-022 div with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 divu SHALL compute the unsigned quotient into LO and the unsigned remainder into HI.
REQ-024 For div/divu with B=0, SHALL run the full DIV_CYCLES busy period and leave HI/LO unchanged at completion.
REQ-025 mthi in IDLE SHALL write HI=A on the edge; mtlo in IDLE SHALL write LO=A on the edge; each takes one cycle, busy stays 0, start stays 0.
REQ-026 During RUN, mdOP 1-6 SHALL be ignored: no restart, no HI/LO write. The hazard unit stalls D while (start|busy) and the D instruction uses md/mt/mf.
REQ-027 mfhi/mflo SHALL never modify state.
REQ-028 MDout SHALL reflect current HI/LO combinationally, including on the cycle a write lands.
REQ-029 On the edge ending RUN, a concurrent new mdOP 1-4 SHALL be ignored because busy is still 1 on that edge; it starts next cycle.
REQ-030 A and B SHALL be sampled only on the start edge; later changes SHALL not affect the result.

Reset
REQ-031 reset high SHALL asynchronously force HI=0, LO=0, busy=0, cnt=0, temp_hi=0, temp_lo=0, and FSM=IDLE, aborting any operation in progress without committing results.
REQ-032 While reset is high, start and MDout SHALL remain purely combinational per REQ-008 and REQ-012, but no state SHALL update.

Verification
REQ-033 mult A=0xFFFFFFFD, B=5 -> start=1 one cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; mfhi then gives MDout=0x00000001.
REQ-035 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO still 0x11/0x22.
REQ-036 mthi A=0x1234 then mflo/mfhi -> HI=0x1234 after one edge, busy=0, MDout=0x1234 on mfhi.
REQ-037 Start mult, assert reset at busy cycle 3 -> busy=0, HI=LO=0 immediately; result never committed.
REQ-038 mult issued while busy, and mult issued on the completion edge -> ignored both times; the same mult held one more cycle then starts with busy=1 for 5 cycles.
